// File: rtl/ft_tx_sched.sv
// ft_tx_sched: arbitrates the FTDI transmit path between the IQ sample FIFO
// and the CPU packet queue. One grant at a time, a one-cycle start pulse per
// burst and a mandatory idle (GAP) cycle between bursts.
// The CPU is favoured but limited to CPU_BURST_MAX consecutive grants while
// the IQ FIFO is also requesting.
// Optional feature: define SCHED_WATCHDOG_EN to abort bursts whose done_i
// pulse does not arrive within TIMEOUT_CYC BUSY cycles.
module ft_tx_sched #(
  parameter int unsigned FIFO_WORDS_PER_TRANS = 1024,
  parameter int unsigned CPU_BURST_MAX        = 4,
  parameter int unsigned TIMEOUT_CYC          = 4096
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        fifo_enough_i,
  input  logic [7:0]  fifoout_wc_i,
  input  logic        done_i,
  output logic        grant_fifo_o,
  output logic        grant_cpu_o,
  output logic        start_o,
  output logic [10:0] burst_len_o,
  output logic        abort_o
);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  localparam int unsigned STREAK_W = (CPU_BURST_MAX < 1) ? 1 : $clog2(CPU_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CPU_BURST_MAX);
  localparam logic [10:0] FIFO_LEN = 11'(FIFO_WORDS_PER_TRANS);

  state_t              state_q, state_d;
  logic                sel_cpu_q, sel_cpu_d;
  logic [10:0]         burst_len_q, burst_len_d;
  logic [7:0]          cpu_done_q, cpu_done_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic [7:0]          cpu_pending;
  logic                cpu_req;
  logic                pick_cpu;

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0]     wd_q, wd_d;
  logic                abort_q, abort_d;
`endif

  // Outstanding CPU words are the write-count distance, modulo 256.
  always_comb begin
    cpu_pending = fifoout_wc_i - cpu_done_q;
    cpu_req     = |cpu_pending;
    pick_cpu    = cpu_req && (!fifo_enough_i || (streak_q < STREAK_MAX));
  end

  // Next-state, grant selection and burst bookkeeping.
  always_comb begin
    state_d     = state_q;
    sel_cpu_d   = sel_cpu_q;
    burst_len_d = burst_len_q;
    cpu_done_d  = cpu_done_q;
    streak_d    = streak_q;
`ifdef SCHED_WATCHDOG_EN
    wd_d        = wd_q;
    abort_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (enable_i && (cpu_req || fifo_enough_i)) begin
          state_d = START;
          if (pick_cpu) begin
            sel_cpu_d   = 1'b1;
            burst_len_d = {3'b000, cpu_pending};
            cpu_done_d  = fifoout_wc_i;
            if (fifo_enough_i && (streak_q < STREAK_MAX)) begin
              streak_d = streak_q + 1'b1;
            end
          end else begin
            sel_cpu_d   = 1'b0;
            burst_len_d = FIFO_LEN;
            streak_d    = '0;
          end
        end
      end
      START: begin
        state_d = BUSY;
`ifdef SCHED_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      BUSY: begin
        if (done_i) begin
          state_d = GAP;
`ifdef SCHED_WATCHDOG_EN
        end else if (wd_q == WD_LAST) begin
          state_d = GAP;
          abort_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_cpu_q   <= 1'b0;
      burst_len_q <= '0;
      cpu_done_q  <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_cpu_q   <= sel_cpu_d;
      burst_len_q <= burst_len_d;
      cpu_done_q  <= cpu_done_d;
      streak_q    <= streak_d;
    end
  end

`ifdef SCHED_WATCHDOG_EN
  // Watchdog counter and registered abort pulse (visible in the GAP cycle).
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

  assign abort_o = abort_q;
`else
  assign abort_o = 1'b0;
`endif

  // Grants decode from state so reset removes them without waiting for a clock.
  always_comb begin
    grant_cpu_o  = ((state_q == START) || (state_q == BUSY)) && sel_cpu_q;
    grant_fifo_o = ((state_q == START) || (state_q == BUSY)) && !sel_cpu_q;
    start_o      = (state_q == START);
    burst_len_o  = burst_len_q;
  end

endmodule

// File: doc/ft_tx_sched.md
FT_TX_SCHED -- requirements
Module: ft_tx_sched

Interface
REQ-001 SHALL provide parameter FIFO_WORDS_PER_TRANS, default 1024, IQ burst length in words.
REQ-002 SHALL provide parameter CPU_BURST_MAX, default 4, max consecutive CPU grants while the IQ FIFO requests.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 4096, watchdog limit in clk_i cycles.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable_i  input  1  permits new grants.
REQ-007 SHALL have port fifo_enough_i  input  1  IQ FIFO holds at least one burst.
REQ-008 SHALL have port fifoout_wc_i  input  8  CPU packet write count, wraps modulo 256.
REQ-009 SHALL have port done_i  input  1  single-cycle pulse from the output mux: burst finished.
REQ-010 SHALL have port grant_fifo_o  output  1  IQ stream owns the FTDI path.
REQ-011 SHALL have port grant_cpu_o  output  1  CPU queue owns the FTDI path.
REQ-012 SHALL have port start_o  output  1  one-cycle pulse at burst start.
REQ-013 SHALL have port burst_len_o  output  11  words in the granted burst.
REQ-014 SHALL have port abort_o  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 SHALL implement states IDLE, START, BUSY, GAP; transitions IDLE->START on grant, START->BUSY unconditionally, BUSY->GAP on done_i or abort, GAP->IDLE unconditionally.
REQ-016 SHALL compute cpu_pending = fifoout_wc_i - cpu_done_cnt modulo 256 (e.g. 0x02 - 0xFE = 4); a CPU request exists when cpu_pending != 0.
REQ-017 SHALL, in IDLE with enable_i=1, grant CPU when only CPU requests, FIFO when only FIFO requests, and CPU when both request unless cpu_streak >= CPU_BURST_MAX, then FIFO.
REQ-018 SHALL increment cpu_streak (saturating at CPU_BURST_MAX) on each CPU grant made while fifo_enough_i=1, and clear it on every FIFO grant.
REQ-019 SHALL, on CPU grant, set burst_len_o = zero-extended cpu_pending and load cpu_done_cnt <= fifoout_wc_i in the same cycle.
REQ-020 SHALL, on FIFO grant, set burst_len_o = FIFO_WORDS_PER_TRANS.
REQ-021 SHALL assert exactly one grant from START through BUSY, hold burst_len_o stable over that interval, and pulse start_o only in START.
REQ-022 SHALL deassert both grants in GAP, guaranteeing at least one idle cycle between bursts.
REQ-023 SHALL ignore done_i outside BUSY; done_i and a new request in the same cycle SHALL still pass through GAP.
REQ-024 SHALL, when enable_i falls mid-burst, let the current burst complete and make no new grants.
REQ-025 SHALL never assert grant_fifo_o and grant_cpu_o together.

Reset
REQ-026 SHALL on reset_n=0 force state IDLE, cpu_done_cnt=0, cpu_streak=0, all grants, start_o, abort_o = 0, burst_len_o = 0.
REQ-027 SHALL on reset mid-burst drop grants immediately without pulsing abort_o.

Configuration
REQ-028 SHALL, with SCHED_WATCHDOG_EN defined, count BUSY cycles and, upon reaching TIMEOUT_CYC without done_i, pulse abort_o, drop grants and go to GAP.
REQ-029 SHALL, without SCHED_WATCHDOG_EN, wait in BUSY indefinitely for done_i and tie abort_o to 0.

Verification
REQ-030 SHALL cover: fifoout_wc_i 0->3, fifo_enough_i=0 -> grant_cpu_o, start_o one cycle, burst_len_o=3, cpu_done_cnt=3.
REQ-031 SHALL cover: fifo_enough_i=1, no CPU -> grant_fifo_o, burst_len_o=1024; done_i -> one GAP cycle with both grants low.
REQ-032 SHALL cover: both requesting continuously, CPU_BURST_MAX=4 -> grant order CPU,CPU,CPU,CPU,FIFO,CPU.
REQ-033 SHALL cover: cpu_done_cnt=0xFE, fifoout_wc_i=0x02 -> burst_len_o=4.
REQ-034 SHALL cover: SCHED_WATCHDOG_EN, TIMEOUT_CYC=16, no done_i -> abort_o pulse after 16 BUSY cycles, then IDLE; without macro -> grant held.
REQ-035 SHALL cover: reset_n low during BUSY -> all outputs 0 asynchronously, abort_o stays 0.
